// File: rtl/up_bus_master.sv
// Byte-serial initiator for the 8-bit uP handshake bus: one address byte plus four data bytes per command.
// Optional per-phase slave response timeout, enabled by defining UP_BUS_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module up_bus_master #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_RW,
  input  logic [7:0]  cmd_reg,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        uP_start,
  output logic        uP_handshake_1,
  output logic        uP_RW,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  input  logic [7:0]  uP_data_in,
  input  logic        async_uP_handshake_2,
  input  logic        async_uP_ack
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_SETUP, ST_HS1, ST_REL,
    ST_NEXT, ST_WAITACK, ST_END, ST_ABORT
  } state_t;

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYCLES - 1);

  state_t         state, state_next;
  logic           hs2_meta, hs2_sync, ack_meta, ack_sync;
  logic [SCW-1:0] setup_cnt;
  logic [2:0]     byte_cnt;
  logic           cmd_rw_q;
  logic [31:0]    cmd_data_q;
  logic [31:0]    rd_buf;
  logic [7:0]     next_wr_byte;
  logic           timed_out;

  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs2_meta <= 1'b0;
      hs2_sync <= 1'b0;
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make the two flops a real two-stage shift; blocking would collapse them into one.
      hs2_meta <= async_uP_handshake_2;
      hs2_sync <= hs2_meta;
      ack_meta <= async_uP_ack;
      ack_sync <= ack_meta;
    end
  end

`ifdef UP_BUS_MASTER_TIMEOUT_EN
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tmo_cnt;

  // Counts cycles spent in the current state; saturates so IDLE never wraps it.
  always_ff @(posedge clk) begin
    if (reset || (state_next != state)) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_LAST)       tmo_cnt <= tmo_cnt + TCW'(1);
  end
  assign timed_out = (tmo_cnt == TMO_LAST);
`else
  assign timed_out   = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      ST_IDLE:    if (cmd_valid) state_next = ST_START;
      ST_START:   state_next = ST_SETUP;
      ST_SETUP:   if (setup_cnt == SETUP_LAST) state_next = ST_HS1;
      ST_HS1:     if (hs2_sync) state_next = ST_REL;
      ST_REL:     if (!hs2_sync) state_next = ST_NEXT;
      ST_NEXT:    state_next = (byte_cnt == 3'd4) ? ST_WAITACK : ST_SETUP;
      ST_WAITACK: if (ack_sync) state_next = ST_END;
      ST_END:     if (!ack_sync) state_next = ST_IDLE;
      ST_ABORT:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
    if (timed_out && (state inside {ST_HS1, ST_REL, ST_WAITACK, ST_END}))
      state_next = ST_ABORT;
  end

  // Data byte following the one just finished; bytes go out least-significant first.
  always_comb begin
    case (byte_cnt)
      3'd0:    next_wr_byte = cmd_data_q[7:0];
      3'd1:    next_wr_byte = cmd_data_q[15:8];
      3'd2:    next_wr_byte = cmd_data_q[23:16];
      default: next_wr_byte = cmd_data_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      setup_cnt      <= '0;
      byte_cnt       <= 3'd0;
      cmd_rw_q       <= 1'b0;
      cmd_data_q     <= 32'h0;
      rd_buf         <= 32'h0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'h0;
      uP_start       <= 1'b0;
      uP_handshake_1 <= 1'b0;
      uP_RW          <= 1'b0;
      uP_data_out    <= 8'h00;
      uP_data_oe     <= 1'b0;
`ifdef UP_BUS_MASTER_TIMEOUT_EN
      rsp_timeout    <= 1'b0;
`endif
    end else begin
      rsp_valid      <= 1'b0;
`ifdef UP_BUS_MASTER_TIMEOUT_EN
      rsp_timeout    <= 1'b0;
`endif
      setup_cnt      <= (state == ST_SETUP) ? setup_cnt + SCW'(1) : '0;
      uP_handshake_1 <= (state_next == ST_HS1);

      case (state)
        ST_IDLE: if (state_next == ST_START) begin
          cmd_rw_q    <= cmd_RW;
          cmd_data_q  <= cmd_data;
          byte_cnt    <= 3'd0;
          uP_start    <= 1'b1;
          uP_RW       <= 1'b0;
          uP_data_out <= cmd_reg;
          uP_data_oe  <= 1'b1;
        end
        ST_HS1: if (state_next == ST_REL && cmd_rw_q) begin
          case (byte_cnt)
            3'd1:    rd_buf[7:0]   <= uP_data_in;
            3'd2:    rd_buf[15:8]  <= uP_data_in;
            3'd3:    rd_buf[23:16] <= uP_data_in;
            3'd4:    rd_buf[31:24] <= uP_data_in;
            default: ;
          endcase
        end
        ST_NEXT: begin
          byte_cnt <= byte_cnt + 3'd1;
          if (byte_cnt != 3'd4) begin
            uP_RW       <= cmd_rw_q;
            uP_data_oe  <= !cmd_rw_q;
            uP_data_out <= cmd_rw_q ? 8'h00 : next_wr_byte;
          end
        end
        ST_END: if (state_next == ST_IDLE) begin
          rsp_valid <= 1'b1;
          if (cmd_rw_q) rsp_data <= rd_buf;
        end
        ST_ABORT: begin
          rsp_valid <= 1'b1;
`ifdef UP_BUS_MASTER_TIMEOUT_EN
          rsp_timeout <= 1'b1;
`endif
        end
        default: ;
      endcase

      // Frame close (normal or aborted) releases the whole bus.
      if ((state_next != state) && (state_next == ST_END || state_next == ST_ABORT)) begin
        uP_start    <= 1'b0;
        uP_RW       <= 1'b0;
        uP_data_out <= 8'h00;
        uP_data_oe  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/up_bus_master.md
# uP_bus_master

Byte-serial bus initiator that drives the shared 8-bit microprocessor handshake bus from the host side. It accepts one 32-bit register read or write command per transaction and sends it as an address byte plus four data bytes. Each byte uses a four-phase handshake_1/handshake_2 exchange, and the slave's ack closes the frame. It sits in the host FPGA, or in the system bench, facing the motion system's uP port, and is the counterpart of the FPGA-side uP interface.

## Interface
- SETUP_CYCLES, 2: cycles data/RW are held stable before uP_handshake_1 rises (≥1).
- TIMEOUT_CYCLES, 4096: per-phase wait limit on slave responses (used only with the timeout feature).
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_RW  in  1  0 = write, 1 = read.
- cmd_reg  in  8  target register number.
- cmd_data  in  32  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse at transaction end.
- rsp_data  out  32  read data (holds last value; 0 after reset).
- rsp_timeout  out  1  qualifies rsp_valid: transaction aborted.
- uP_start  out  1  frame active.
- uP_handshake_1  out  1  master byte strobe.
- uP_RW  out  1  direction of current data bytes.
- uP_data_out  out  8  bus drive value.
- uP_data_oe  out  1  tristate enable for uP_data_out.
- uP_data_in  in  8  bus sample value.
- async_uP_handshake_2  in  1  slave byte strobe; two-flop synchronised internally.
- async_uP_ack  in  1  slave frame ack; two-flop synchronised internally.

## Operation
- All outputs reset to 0; the synchroniser flops reset to 0; the FSM resets to IDLE.
- Frame layout: byte 0 = cmd_reg, always written. Bytes 1–4 = data, least-significant byte first. Data bytes are written when cmd_RW=0 and read when cmd_RW=1.
- FSM states:
  - IDLE: on accept, latch cmd; go to START.
  - START: uP_start=1, uP_RW=0, drive cmd_reg with oe=1; go to SETUP.
  - SETUP: count SETUP_CYCLES; go to HS1.
  - HS1: handshake_1=1; wait for sync handshake_2=1. On a read data byte, capture uP_data_in into byte slot n in the cycle it is seen high. Go to REL.
  - REL: handshake_1=0; wait for sync handshake_2=0; go to NEXT.
  - NEXT: byte counter n (3-bit, 0..4) +1.
    - If n was 4, go to WAITACK.
    - Otherwise load the next byte, set uP_RW=cmd_RW, set oe=!cmd_RW, go to SETUP.
  - WAITACK: wait for sync ack=1; go to END.
  - END: uP_start=0, oe=0; wait for sync ack=0; pulse rsp_valid; go to IDLE.
  - ABORT: handshake_1=0, uP_start=0, oe=0; pulse rsp_valid with rsp_timeout=1; go to IDLE.
- The read turnaround takes one full SETUP interval: oe drops, and uP_RW=1, at least SETUP_CYCLES before the first read handshake_1.
- rsp_data updates only on a successful read completion. A write or abort leaves it unchanged.
- A cmd_valid arriving while busy is not accepted (cmd_ready=0) and needs no buffering.
- Reset mid-frame returns to IDLE the next edge. All bus outputs go to 0 and rsp_valid is not pulsed.

## Timing
- Synchronised slave inputs lag the pins by 2 cycles. Handshake edges are reacted to 3 cycles after the pin edge: 2 sync + 1 FSM.
- cmd accept to uP_start high: 1 cycle.
- uP_start high to first handshake_1 rise: 1 + SETUP_CYCLES cycles.
- Per byte, with a slave responding instantly: SETUP_CYCLES + 2×(3) + 1 cycles.
- rsp_valid occurs 1 cycle after sync ack falls. It is high for exactly 1 cycle.
- Within any byte, uP_data_out, uP_data_oe and uP_RW change only in START/NEXT/END/ABORT, never while handshake_1=1.

## Configuration
- UP_BUS_MASTER_TIMEOUT_EN defined:
  - A counter reloads on every state change.
  - If it reaches TIMEOUT_CYCLES while in HS1, REL, WAITACK or END, the FSM goes to ABORT.
- Undefined: no counter; the FSM waits indefinitely, and rsp_timeout is tied 0.

## Test plan
- Write, cmd_reg=0x05, cmd_data=0xDEADBEEF, zero-delay slave model -> bus bytes 05,EF,BE,AD,DE. uP_RW=0 throughout. rsp_valid=1, rsp_timeout=0, rsp_data unchanged.
- Read, cmd_reg=0x12, slave returns bytes 78,56,34,12 -> uP_RW=1 and oe=0 for bytes 1–4. rsp_data=0x12345678.
- Slave delays each handshake_2 response by 17 cycles -> handshake_1 is held high/low until the response. There are no extra strobes, and data is stable while handshake_1=1.
- With UP_BUS_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=64, the slave never raises handshake_2 on byte 2 -> ABORT after 64 cycles. rsp_valid=rsp_timeout=1, and all bus outputs go to 0.
- Reset asserted mid-byte 3 of a write -> next cycle all outputs are 0 and cmd_ready=1. No rsp_valid. A following read completes correctly.
- cmd_valid held high for back-to-back write then read -> the second command is accepted only after the first rsp_valid. cmd_ready is low throughout the first frame.
